// File: rtl/hex_seg_driver.sv
// Single HEX digit driver: registered nibble decode, blank, blink and PWM dimming.
// Optional raw segment mode is enabled with HEX_SEG_DRIVER_RAW_MODE_EN.
module hex_seg_driver #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BLINK_HZ    = 2,
  parameter int PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_port,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [6:0]          hex_n,
  output logic                update
);

  localparam int BLINK_HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  if (BLINK_HALF < 2) begin : g_bad_blink
    $error("hex_seg_driver: BLINK_HALF must be >= 2");
  end

`ifdef HEX_SEG_DRIVER_RAW_MODE_EN
  localparam logic [7:0] IN_MASK = 8'hFF;
`else
  localparam logic [7:0] IN_MASK = 8'h3F;
`endif

  logic [7:0]          in_m;
  logic [7:0]          in_q;
  logic                first_q;
  logic                chg;
  logic                chg_q;
  logic [6:0]          seg_r;
  logic [6:0]          seg_d;
  logic [6:0]          dec;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic                visible;
  logic                on;
  logic [6:0]          hex_d;

  assign in_m = in_port & IN_MASK;
  // The first cycle out of reset always counts as a new value.
  assign chg  = (in_m != in_q) | first_q;

  always_comb begin
    dec = 7'h00;
    case (in_q[3:0])
      4'h0: dec = 7'h3F;
      4'h1: dec = 7'h06;
      4'h2: dec = 7'h5B;
      4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66;
      4'h5: dec = 7'h6D;
      4'h6: dec = 7'h7D;
      4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F;
      4'h9: dec = 7'h6F;
      4'hA: dec = 7'h77;
      4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39;
      4'hD: dec = 7'h5E;
      4'hE: dec = 7'h79;
      default: dec = 7'h71;
    endcase
  end

  always_comb begin
    seg_d   = in_q[4] ? 7'h00 : dec;
    visible = ~in_q[5] | blink_phase;
`ifdef HEX_SEG_DRIVER_RAW_MODE_EN
    if (in_q[7]) begin
      seg_d   = in_q[6:0];
      visible = 1'b1;
    end
`endif
    on    = (brightness == {PWM_BITS{1'b1}}) | (pwm_cnt < brightness);
    hex_d = ~(seg_d & {7{on & visible}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q        <= '0;
      first_q     <= 1'b1;
      chg_q       <= 1'b0;
      seg_r       <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      hex_n       <= 7'h7F;
      update      <= 1'b0;
    end else begin
      in_q    <= in_m;
      first_q <= 1'b0;
      chg_q   <= chg;
      update  <= chg_q;
      seg_r   <= seg_d;
      hex_n   <= hex_d;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (chg) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_seg_driver.sv
// Directed bench for hex_seg_driver (BLINK_HALF = 4, PWM_BITS = 4).
module tb_hex_seg_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_port;
  logic [3:0] brightness;
  logic [6:0] hex_n;
  logic       update;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] exp_seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  hex_seg_driver #(
    .CLK_FREQ_HZ(8),
    .BLINK_HZ   (1),
    .PWM_BITS   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .brightness(brightness),
    .hex_n     (hex_n),
    .update    (update)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int cnt;
    logic [6:0] e;
    reset      = 1'b1;
    in_port    = 8'h00;
    brightness = 4'hF;
    tick();
    tick();
    chk("rst_hex", 32'(hex_n), 32'h7F);
    chk("rst_upd", 32'(update), 32'h0);
    reset = 1'b0;
    tick();
    tick();
    chk("post_rst_hex", 32'(hex_n), 32'h40);
    chk("post_rst_upd", 32'(update), 32'h1);
    tick();
    chk("post_rst_upd_lo", 32'(update), 32'h0);

    for (int v = 0; v < 16; v++) begin
      in_port = 8'(v);
      tick();
      tick();
      chk($sformatf("dec_%0h", v), 32'(hex_n), 32'(exp_seg[v]));
      if (v != 0) chk($sformatf("upd_%0h", v), 32'(update), 32'h1);
      tick();
      chk($sformatf("upd_lo_%0h", v), 32'(update), 32'h0);
      tick();
    end

    in_port = 8'h23;
    tick();
    for (int k = 1; k <= 14; k++) begin
      tick();
      e = (((k - 1) / 4) % 2 == 0) ? 7'h30 : 7'h7F;
      chk($sformatf("blink_%0d", k), 32'(hex_n), 32'(e));
    end
    in_port = 8'h25;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("restart_%0d", k), 32'(hex_n), 32'h12);
    end
    tick();
    chk("restart_dark", 32'(hex_n), 32'h7F);

    in_port = 8'h18;
    tick();
    tick();
    chk("blank", 32'(hex_n), 32'h7F);
    in_port = 8'h08;
    tick();
    tick();
    chk("unblank", 32'(hex_n), 32'h00);

    brightness = 4'h4;
    tick();
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (hex_n == 7'h00) cnt++;
    end
    chk("pwm4_on", 32'(cnt), 32'd4);
    brightness = 4'h0;
    tick();
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (hex_n == 7'h7F) cnt++;
    end
    chk("pwm0_dark", 32'(cnt), 32'd16);

    brightness = 4'hF;
    in_port    = 8'hC9;
    tick();
    tick();
`ifdef HEX_SEG_DRIVER_RAW_MODE_EN
    chk("c9", 32'(hex_n), 32'h36);
`else
    chk("c9", 32'(hex_n), 32'h10);
`endif

    reset = 1'b1;
    tick();
    chk("midrst_hex", 32'(hex_n), 32'h7F);
    chk("midrst_upd", 32'(update), 32'h0);
    reset = 1'b0;
    tick();
    tick();
`ifdef HEX_SEG_DRIVER_RAW_MODE_EN
    chk("rerun_hex", 32'(hex_n), 32'h36);
`else
    chk("rerun_hex", 32'(hex_n), 32'h10);
`endif
    chk("rerun_upd", 32'(update), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
